// File: rtl/fifo_drain_display_pkg.sv
// Shared types and defaults for the FIFO drain/display block.
package fifo_drain_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_HOLD_CYCLES = 50_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } drain_state_e;

  // A one-cycle dwell still needs a 1-bit counter.
  function automatic int timer_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_display_if.sv
// FIFO read-side bus: the drain block is the master, the FIFO the slave.
interface fifo_drain_display_if
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             fifo_rd;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;

  modport master (output fifo_rd, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_data);

endinterface

// File: rtl/fifo_drain_display_hold_timer.sv
// Loadable down-counter that sets the dwell time of each displayed word.
module hold_timer
  import fifo_drain_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int TW          = timer_width(HOLD_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] count;

  // Counts down to zero and parks there until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/fifo_drain_display.sv
// Pulls words from the FIFO (automatically or per step pulse) and holds each on the display.
module fifo_drain_display
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 auto_mode,
  input  logic                 step,
  fifo_drain_display_if.master fifo,
  output logic [WIDTH-1:0]     disp_data,
  output logic                 disp_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     drained_count
);

  localparam int TW = timer_width(HOLD_CYCLES);

  drain_state_e state;
  drain_state_e state_next;
  logic         timer_load;
  logic         timer_done;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .TW          (TW)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (TW'(HOLD_CYCLES - 1)),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Inputs are only looked at in IDLE, so a started fetch always runs to completion.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !fifo.fifo_empty && (auto_mode || step)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        timer_load = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (timer_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fifo.fifo_rd = (state == REQ);
  assign busy         = (state != IDLE);

  // The FIFO presents the word one cycle after the strobe, i.e. during CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data     <= '0;
      disp_valid    <= 1'b0;
      drained_count <= '0;
    end else if (state == CAPTURE) begin
      disp_data     <= fifo.fifo_data;
      disp_valid    <= 1'b1;
      drained_count <= drained_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_drain_display.sv
// Directed bench for fifo_drain_display with HOLD_CYCLES=4 and a behavioural FIFO.
module tb_fifo_drain_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       auto_mode;
  logic       step;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       busy;
  logic [7:0] drained_count;
  logic [7:0] disp_data_w;
  logic       disp_valid_w;
  logic       busy_w;
  logic [1:0] drained_count_w;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int rd_back2back = 0;
  logic prev_rd = 1'b0;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] fifo_out = 8'h00;

  fifo_drain_display_if #(.WIDTH(8)) bus ();
  fifo_drain_display_if #(.WIDTH(8)) bus_w ();

  fifo_drain_display #(.WIDTH(8), .HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .auto_mode     (auto_mode),
    .step          (step),
    .fifo          (bus),
    .disp_data     (disp_data),
    .disp_valid    (disp_valid),
    .busy          (busy),
    .drained_count (drained_count)
  );

  // Narrow-counter twin sees identical inputs, so it tracks the main DUT modulo 4.
  fifo_drain_display #(.WIDTH(8), .HOLD_CYCLES(4), .CNT_W(2)) dut_w (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .auto_mode     (auto_mode),
    .step          (step),
    .fifo          (bus_w),
    .disp_data     (disp_data_w),
    .disp_valid    (disp_valid_w),
    .busy          (busy_w),
    .drained_count (drained_count_w)
  );

  always #5 clk = ~clk;

  assign bus.fifo_empty   = (rd_ptr == wr_ptr);
  assign bus.fifo_data    = fifo_out;
  assign bus_w.fifo_empty = (rd_ptr == wr_ptr);
  assign bus_w.fifo_data  = fifo_out;

  // FIFO model: registered read port, data valid the cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_rd <= bus.fifo_rd;
    if (bus.fifo_rd === 1'b1) begin
      rd_pulses <= rd_pulses + 1;
      if (prev_rd === 1'b1) rd_back2back <= rd_back2back + 1;
      if (rd_ptr != wr_ptr) begin
        fifo_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic apply_stimulus(input logic r, input logic en, input logic am, input logic st);
    reset = r;
    enable = en;
    auto_mode = am;
    step = st;
  endtask

  task automatic wait_rd(input string tag, output int at_cyc);
    int n = 0;
    while (bus.fifo_rd !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, bus.fifo_rd, 1);
    at_cyc = cyc;
  endtask

  initial begin
    int prev_cyc;
    int now_cyc;
    int rd_base;
    logic [7:0] exp_count;
    logic [1:0] exp_wrap;

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_output("rst_fifo_rd", bus.fifo_rd, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_disp_valid", disp_valid, 0);
    check_output("rst_disp_data", disp_data, 8'h00);
    check_output("rst_count", drained_count, 0);

    // Empty FIFO: nothing may be fetched even in auto mode.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check_output("empty_rd_pulses", rd_pulses, 0);
    check_output("empty_busy", busy, 0);
    check_output("empty_disp_valid", disp_valid, 0);
    check_output("empty_count", drained_count, 0);

    // Single step of 8'h3C.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    push(8'h3C);
    repeat (2) @(negedge clk);
    check_output("step_no_fetch_without_step", busy, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_output("step_rd_k", bus.fifo_rd, 1);
    check_output("step_busy_k", busy, 1);
    @(negedge clk);
    check_output("step_rd_k1", bus.fifo_rd, 0);
    check_output("step_valid_k1", disp_valid, 0);
    @(negedge clk);
    check_output("step_data_k2", disp_data, 8'h3C);
    check_output("step_valid_k2", disp_valid, 1);
    check_output("step_count_k2", drained_count, 1);
    repeat (3) @(negedge clk);
    check_output("step_busy_k5", busy, 1);
    @(negedge clk);
    check_output("step_busy_k6", busy, 0);
    check_output("step_rd_total", rd_pulses, 1);

    // Auto drain of five words from a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("auto_rst_count", drained_count, 0);
    for (int w = 1; w <= 5; w++) push(8'(w));
    rd_base = rd_pulses;
    auto_mode = 1'b1;
    prev_cyc = 0;
    exp_count = 8'd0;
    exp_wrap = 2'd0;
    for (int w = 1; w <= 5; w++) begin
      wait_rd($sformatf("auto_rd_%0d", w), now_cyc);
      if (w > 1) check_output($sformatf("auto_spacing_%0d", w), now_cyc - prev_cyc, 7);
      prev_cyc = now_cyc;
      repeat (2) @(negedge clk);
      exp_count = exp_count + 8'd1;
      exp_wrap = exp_wrap + 2'd1;
      check_output($sformatf("auto_data_%0d", w), disp_data, 8'(w));
      check_output($sformatf("auto_count_%0d", w), drained_count, exp_count);
      check_output($sformatf("wrap_count_%0d", w), drained_count_w, exp_wrap);
    end
    repeat (12) @(negedge clk);
    check_output("auto_idle_busy", busy, 0);
    check_output("auto_rd_total", rd_pulses - rd_base, 5);
    check_output("auto_final_count", drained_count, 5);
    check_output("wrap_final_count", drained_count_w, 1);

    // Step held across three HOLD edges must not start another fetch.
    auto_mode = 1'b0;
    push(8'hAA);
    push(8'hBB);
    rd_base = rd_pulses;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    check_output("ign_data", disp_data, 8'hAA);
    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    check_output("ign_rd_delta", rd_pulses - rd_base, 1);
    check_output("ign_count", drained_count, 6);
    check_output("ign_busy", busy, 0);

    // Drop enable mid-HOLD: BB completes, CC stays queued.
    push(8'hCC);
    rd_base = rd_pulses;
    auto_mode = 1'b1;
    wait_rd("en_rd_bb", now_cyc);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    check_output("en_busy_hold", busy, 1);
    repeat (12) @(negedge clk);
    check_output("en_data", disp_data, 8'hBB);
    check_output("en_count", drained_count, 7);
    check_output("en_rd_delta", rd_pulses - rd_base, 1);
    check_output("en_busy_after", busy, 0);

    // Reset while in CAPTURE discards CC.
    enable = 1'b1;
    wait_rd("rstmid_rd_cc", now_cyc);
    @(negedge clk);
    check_output("rstmid_busy_capture", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_output("rstmid_data", disp_data, 8'h00);
    check_output("rstmid_valid", disp_valid, 0);
    check_output("rstmid_count", drained_count, 0);
    check_output("rstmid_busy", busy, 0);
    check_output("rstmid_wrap_count", drained_count_w, 0);
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_output("no_back_to_back_rd", rd_back2back, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
